instruction_cache_controller: RTL
=================================

// Module: instruction_cache_controller
// PURPOSE
//  Direct-mapped instruction cache plus FSM that sequences instruction_memory block reads.
//  Sits between CPU fetch (PC -> INSTRUCTION) and instruction_memory's 128-bit block interface.
//  Hits return a word in the same cycle; misses stall the CPU via BUSYWAIT while one 16-byte block is fetched.
// PARAMETERS
//  NUM_SETS   8    cache lines; power of two
//  INDEX_W    3    log2(NUM_SETS)
//  TAG_W      25   PC[31:4+INDEX_W] width = 28-INDEX_W
// PORTS
//  CLK            in   1    clock; all state updates on posedge
//  RESET          in   1    synchronous, active-high reset
//  PC             in   32   fetch byte address; word aligned, PC[1:0] ignored
//  INSTRUCTION    out  32   fetched word; valid when BUSYWAIT==0
//  BUSYWAIT       out  1    CPU stall; combinational from state and hit
//  MEM_READ       out  1    block read request to instruction_memory
//  MEM_ADDRESS    out  28   block address = PC[31:4] latched at miss
//  MEM_READDATA   in   128  block from memory; byte k at [8k+7:8k]
//  MEM_BUSYWAIT   in   1    memory busy; low after data is loaded
// BEHAVIOUR
//  Address split: offset=PC[3:2], index=PC[4+INDEX_W-1:4], tag=PC[31:4+INDEX_W].
//  Line storage: valid bit, TAG_W tag, 128-bit data per set.
//  Word select: offset n -> data[32n+31:32n] (little-endian, matches memory byte order).
//  hit = valid[index] && tag[index]==tag; combinational, in IDLE only.
//  Reset: state=IDLE; all valid=0; MEM_READ=0; MEM_ADDRESS=0; INSTRUCTION=0 on reset cycle; BUSYWAIT=0.
//  FSM states: IDLE, MEM_READ, UPDATE (encoding in package).
//   IDLE: hit -> BUSYWAIT=0, INSTRUCTION=selected word, stay.
//         miss -> BUSYWAIT=1 same cycle; next edge: latch MEM_ADDRESS=PC[31:4], go MEM_READ.
//   MEM_READ: MEM_READ=1, BUSYWAIT=1; go UPDATE at first edge where MEM_BUSYWAIT sampled 0
//             (never on the entry edge: memory raises MEM_BUSYWAIT combinationally on MEM_READ).
//   UPDATE: MEM_READ=0, BUSYWAIT=1; on edge write data=MEM_READDATA, tag=MEM_ADDRESS tag field,
//           valid=1 to set MEM_ADDRESS index; go IDLE. Next IDLE cycle hits, BUSYWAIT falls.
//  Miss latency: fill takes IDLE detect edge + memory-done edge + 1 clean edge + UPDATE edge;
//   with current memory: BUSYWAIT high 4 cycles, word returned in cycle 5.
//  Line fill uses latched MEM_ADDRESS, not live PC; PC change during stall does not corrupt fill.
//   After UPDATE, hit/miss is re-evaluated on current PC (may start a new miss).
//  Conflict miss: same index, different tag -> line overwritten unconditionally (read-only, no writeback).
//  Valid=0 line never hits, even if stored tag matches.
//  RESET in MEM_READ/UPDATE: abort; MEM_READ drops same edge; partial fill never written; all lines invalid.
//  RESET has priority over every transition; asserted with a miss -> no request issued.
//  MEM_READDATA sampled only in UPDATE; ignored elsewhere.
//  No X on outputs after first reset edge; INSTRUCTION holds last value when BUSYWAIT=1.
// STRUCTURE
//  icache_pkg: state typedef {IDLE, MEM_READ, UPDATE}, OFFSET_W=2, BLOCK_W=128, ADDR_W=32,
//   MEM_ADDR_W=28, field-slice constants derived from INDEX_W.
//  Sub-module icache_line_array: valid/tag/data storage, sync write port (index, tag, data, we),
//   async read by index; clears valid on RESET.
//  Top: FSM, hit compare, word mux, MEM_ADDRESS latch.
// TESTING
//  Cold miss: RESET, then PC=0x0 -> BUSYWAIT=1, MEM_READ=1 MEM_ADDRESS=0x0; after fill INSTRUCTION=mem bytes[3:0].
//  Spatial hits: after fill at 0x0, PC=0x4,0x8,0xC -> BUSYWAIT=0 every cycle, words 1,2,3 of block 0, MEM_READ=0.
//  Conflict: fill 0x00, then PC=0x80 (index 0, tag 1) -> miss, MEM_ADDRESS=0x8; then PC=0x00 misses again.
//  All sets: PC=0x00..0x70 step 0x10 -> 8 misses; second pass -> 8 hits, zero stall cycles.
//  Reset mid-miss: RESET while in MEM_READ -> MEM_READ=0 next edge, state IDLE; PC=0x0 misses again.
//  PC moves during stall: miss at 0x20, change PC to 0x40 in MEM_READ -> line 2 filled from block 0x2, then miss at 0x40.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-field constants for the direct-mapped instruction cache.
package icache_pkg;

    localparam int NUM_SETS   = 8;
    localparam int INDEX_W    = $clog2(NUM_SETS);
    localparam int ADDR_W     = 32;
    localparam int MEM_ADDR_W = 28;
    localparam int OFFSET_W   = 2;
    localparam int BLOCK_W    = 128;
    localparam int WORD_W     = 32;
    localparam int TAG_W      = MEM_ADDR_W - INDEX_W;
    localparam int OFFSET_LSB = 2;
    localparam int INDEX_LSB  = OFFSET_LSB + OFFSET_W;
    localparam int TAG_LSB    = INDEX_LSB + INDEX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEM_RD = 2'd1,
        UPDATE = 2'd2
    } state_e;

    // Word n of a block lives at bits [32n+31:32n].
    function automatic logic [WORD_W-1:0] sel_word(
        input logic [BLOCK_W-1:0]  blk,
        input logic [OFFSET_W-1:0] off
    );
        return blk[{off, 5'b0} +: WORD_W];
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: synchronous fill port, asynchronous read by index.
module icache_line_array
    import icache_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               we_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [BLOCK_W-1:0] wr_data_i,
    input  logic [INDEX_W-1:0] rd_index_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [BLOCK_W-1:0] rd_data_o
);

    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [BLOCK_W-1:0]  data_q [NUM_SETS];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag/data need no reset: an invalid line is never read as a hit.
    always_ff @(posedge CLK) begin
        if (we_i && !RESET) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/instruction_cache_controller.sv
// Direct-mapped I-cache: hit compare, word mux and block-fill FSM
// in front of a 128-bit instruction memory.
module instruction_cache_controller
    import icache_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_W-1:0]     PC,
    output logic [WORD_W-1:0]     INSTRUCTION,
    output logic                  BUSYWAIT,
    output logic                  MEM_READ,
    output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
    input  logic [BLOCK_W-1:0]    MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    state_e state_q, state_d;
    logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]     instr_q, instr_d;

    logic [OFFSET_W-1:0] pc_off;
    logic [INDEX_W-1:0]  pc_index;
    logic [TAG_W-1:0]    pc_tag;
    logic                unused_pc;

    assign pc_off    = PC[INDEX_LSB-1:OFFSET_LSB];
    assign pc_index  = PC[TAG_LSB-1:INDEX_LSB];
    assign pc_tag    = PC[ADDR_W-1:TAG_LSB];
    assign unused_pc = ^PC[OFFSET_LSB-1:0];

    logic               line_valid;
    logic [TAG_W-1:0]   line_tag;
    logic [BLOCK_W-1:0] line_data;
    logic               fill_we;
    logic               busy;
    logic               hit;
    logic [WORD_W-1:0]  hit_word;

    // Fill is addressed from the latched block address, never the live PC.
    icache_line_array u_lines (
        .CLK        (CLK),
        .RESET      (RESET),
        .we_i       (fill_we && !RESET),
        .wr_index_i (mem_addr_q[INDEX_W-1:0]),
        .wr_tag_i   (mem_addr_q[MEM_ADDR_W-1:INDEX_W]),
        .wr_data_i  (MEM_READDATA),
        .rd_index_i (pc_index),
        .rd_valid_o (line_valid),
        .rd_tag_o   (line_tag),
        .rd_data_o  (line_data)
    );

    assign hit      = (state_q == IDLE) && line_valid
                      && (line_tag == pc_tag);
    assign hit_word = sel_word(line_data, pc_off);

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        busy       = 1'b0;
        MEM_READ   = 1'b0;
        fill_we    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!hit) begin
                    busy       = 1'b1;
                    mem_addr_d = PC[ADDR_W-1:INDEX_LSB];
                    state_d    = MEM_RD;
                end
            end
            MEM_RD: begin
                busy     = 1'b1;
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) state_d = UPDATE;
            end
            UPDATE: begin
                busy    = 1'b1;
                fill_we = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign instr_d = hit ? hit_word : instr_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
        end
    end

    // Outputs are forced quiet while RESET is held so nothing is X pre-reset.
    assign BUSYWAIT    = busy && !RESET;
    assign INSTRUCTION = RESET ? '0 : instr_d;
    assign MEM_ADDRESS = mem_addr_q;

endmodule
